// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated in reverse order
// by rotating C/D right. Valid/ready handshake on both the ciphertext and plaintext sides.
module des_decrypt_core #(
    parameter int unsigned KEY_PARITY_CHECK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        key_err
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam int IpTbl [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FpTbl [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int ETbl [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31,
        32, 1};

    localparam int PTbl [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int Pc1Tbl [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int Pc2Tbl [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
        29, 32};

    // Indexed [box][row*16 + column]
    localparam int SboxTbl [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Tables use DES numbering: bit 1 is the MSB of each vector
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IpTbl[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FpTbl[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - ETbl[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - PTbl[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - Pc1Tbl[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - Pc2Tbl[i])];
        return y;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        x = e_perm(r) ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[6'(47 - 6 * j) -: 6];
            s[5'(31 - 4 * j) -: 4] = 4'(SboxTbl[3'(j)][{b[5], b[0], b[4:1]}]);
        end
        return p_perm(s);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] out_block_q, out_block_d;
    logic        key_err_q, key_err_d;

    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;
    logic [31:0] f_out;
    logic        parity_bad;

    // Round 1 reuses C0/D0 (= C16/D16); rounds 2, 9 and 16 undo a 1-bit shift, others 2
    always_comb begin
        shift = 2'd2;
        if (rnd_q == 5'd1) begin
            shift = 2'd0;
        end else if (rnd_q == 5'd2 || rnd_q == 5'd9 || rnd_q == 5'd16) begin
            shift = 2'd1;
        end
        case (shift)
            2'd0:    begin c_rot = c_q;                    d_rot = d_q;                    end
            2'd1:    begin c_rot = {c_q[0], c_q[27:1]};    d_rot = {d_q[0], d_q[27:1]};    end
            default: begin c_rot = {c_q[1:0], c_q[27:2]};  d_rot = {d_q[1:0], d_q[27:2]};  end
        endcase
        f_out = f_func(r_q, pc2_perm({c_rot, d_rot}));
    end

    always_comb begin
        parity_bad = 1'b0;
        for (int i = 0; i < 8; i++) parity_bad = parity_bad | ~(^in_key[8 * i +: 8]);
    end

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        rnd_d       = rnd_q;
        out_block_d = out_block_q;
        key_err_d   = key_err_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    {l_d, r_d} = ip_perm(in_block);
                    {c_d, d_d} = pc1_perm(in_key);
                    rnd_d      = 5'd1;
                    key_err_d  = (KEY_PARITY_CHECK != 0) && parity_bad;
                    state_d    = StRound;
                end
            end
            StRound: begin
                l_d = r_q;
                r_d = l_q ^ f_out;
                c_d = c_rot;
                d_d = d_rot;
                if (rnd_q == 5'd16) begin
                    out_block_d = fp_perm({r_d, r_q});
                    state_d     = StDone;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            rnd_q       <= '0;
            out_block_q <= '0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            rnd_q       <= rnd_d;
            out_block_q <= out_block_d;
            key_err_q   <= key_err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_block = out_block_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors, backpressure, back-to-back, mid-run reset.
module tb_des_decrypt_core;

    localparam logic [63:0] Key1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] Ct1  = 64'h85E813540F0AB405;
    localparam logic [63:0] Pt1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] Key2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] Ct2  = 64'h0000000000000000;
    localparam logic [63:0] Pt2  = 64'h8787878787878787;
    localparam logic [63:0] Key3 = 64'h0000000000000000;
    localparam logic [63:0] Ct3  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] Pt3  = 64'h0000000000000000;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [63:0] in_block, in_key;
    logic        in_ready, out_valid, key_err;
    logic [63:0] out_block;
    logic        in_ready0, out_valid0, key_err0;
    logic [63:0] out_block0;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    typedef struct packed {
        logic [63:0] blk;
        logic        err1;
        logic        err0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    des_decrypt_core #(.KEY_PARITY_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .key_err(key_err)
    );

    des_decrypt_core #(.KEY_PARITY_CHECK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_block(in_block), .in_key(in_key), .out_valid(out_valid0), .out_ready(out_ready),
        .out_block(out_block0), .key_err(key_err0)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Offer a transaction, push its expectation, return just after the accept edge
    task automatic send(input logic [63:0] key, input logic [63:0] blk,
                        input logic [63:0] exp_blk, input logic e1, input logic e0);
        int n;
        in_key   = key;
        in_block = blk;
        in_valid = 1'b1;
        sb.push_back('{blk: exp_blk, err1: e1, err0: e0});
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_block = ~blk;
        in_key   = ~key;
        chk1("busy_in_ready", in_ready, 1'b0);
    endtask

    // Wait for out_valid (bounded), then pop the scoreboard and compare
    task automatic get(input string tag, output int cycles);
        exp_t e;
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            step();
            cycles++;
        end
        chk1({tag, "_out_valid"}, out_valid, 1'b1);
        chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk64({tag, "_out_block"}, out_block, e.blk);
            chk1({tag, "_key_err"}, key_err, e.err1);
            chk64({tag, "_out_block_nochk"}, out_block0, e.blk);
            chk1({tag, "_key_err_nochk"}, key_err0, e.err0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        in_key    = '0;
        step();
        step();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_out_block", out_block, 64'h0);
        chk1("rst_key_err", key_err, 1'b0);
        chk1("rst_key_err_nochk", key_err0, 1'b0);
        rst_n = 1'b1;
        step();

        // T1 with output stall (T4); a competing request is offered during the stall
        send(Key1, Ct1, Pt1, 1'b0, 1'b0);
        get("t1", lat);
        chk64("t1_latency", 64'(lat), 64'd16);
        in_valid = 1'b1;
        in_block = Ct2;
        in_key   = Key2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk64("stall_out_block", out_block, Pt1);
            chk1("stall_out_valid", out_valid, 1'b1);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk1("t1_hs_out_valid", out_valid, 1'b0);
        chk1("t1_hs_in_ready", in_ready, 1'b1);

        // T2 and T3 (parity error only reported with checking enabled)
        send(Key2, Ct2, Pt2, 1'b0, 1'b0);
        get("t2", lat);
        chk64("t2_latency", 64'(lat), 64'd16);
        step();
        chk1("t2_hs_out_valid", out_valid, 1'b0);
        send(Key3, Ct3, Pt3, 1'b1, 1'b0);
        get("t3", lat);
        step();
        chk1("t3_hs_in_ready", in_ready, 1'b1);

        // T5: back-to-back with in_valid held; input changes during T1 must not matter
        send(Key1, Ct1, Pt1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_block = Ct2;
        in_key   = Key2;
        sb.push_back('{blk: Pt2, err1: 1'b0, err0: 1'b0});
        get("b2b1", lat);
        step();
        chk1("b2b_hs_out_valid", out_valid, 1'b0);
        chk1("b2b_hs_in_ready", in_ready, 1'b1);
        step();
        chk1("b2b_second_accept", in_ready, 1'b0);
        in_valid = 1'b0;
        in_block = '1;
        get("b2b2", lat);
        chk64("b2b2_latency", 64'(lat), 64'd16);
        step();

        // T6: reset during round 8 of T1, then T2
        send(Key1, Ct1, Pt1, 1'b0, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk64("midrst_out_block", out_block, 64'h0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_key_err", key_err, 1'b0);
        rst_n = 1'b1;
        sb.delete();
        send(Key2, Ct2, Pt2, 1'b0, 1'b0);
        get("post_rst", lat);
        chk64("post_rst_latency", 64'(lat), 64'd16);
        step();
        chk1("post_rst_hs", out_valid, 1'b0);
        chk64("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
